store_buffer_dmem: RTL and testbench



---
 rtl/store_buffer_dmem_if.sv | 12 +
 rtl/store_buffer_dmem.sv | 113 +++++++++++
 tb/tb_store_buffer_dmem.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/store_buffer_dmem_if.sv
// Memory-stage to data-memory bus: store request, load request, byte address,
// store data, and the combinational load data coming back.
interface store_buffer_dmem_if;
  logic        mem_en;
  logic        rd_en;
  logic [31:0] addr;
  logic [31:0] mem_data;
  logic [31:0] mem_out;

  modport master (output mem_en, rd_en, addr, mem_data, input mem_out);
  modport slave  (input mem_en, rd_en, addr, mem_data, output mem_out);
endinterface

// File: rtl/store_buffer_dmem.sv
// Data memory with a posted circular store buffer, youngest-match load forwarding
// and opportunistic drain into a single-write-port word array. Optional DMEM_STATS_EN.
module store_buffer_dmem #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 10
) (
  input  logic                         clk,
  input  logic                         reset,
  store_buffer_dmem_if.slave           bus,
  output logic [$clog2(DEPTH+1)-1:0]   sb_count,
  output logic                         sb_empty
`ifdef DMEM_STATS_EN
  ,
  output logic [31:0]                  stat_fwd,
  output logic [31:0]                  stat_drain
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [31:0]       mem [2**ADDR_W];

  logic [DEPTH-1:0]  sb_valid;
  logic [ADDR_W-1:0] sb_addr [DEPTH];
  logic [31:0]       sb_data [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;

  logic [ADDR_W-1:0] word;
  logic              buf_full;
  logic              do_enq;
  logic              do_drain;
  logic              fwd_hit;
  logic [31:0]       fwd_data;

  assign word     = bus.addr[ADDR_W+1:2];
  assign buf_full = (count == CNT_W'(DEPTH));
  assign do_enq   = bus.mem_en && !reset;
  // A full buffer facing a store must retire its head even under a load.
  assign do_drain = !reset && (count != '0) &&
                    (!bus.rd_en || (buf_full && bus.mem_en));

  // Walk oldest to youngest so the last match wins; the draining head is still
  // visible here, so a forced drain never hides pre-edge data from a load.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [PTR_W-1:0] idx;
      idx = head + PTR_W'(i);
      if (sb_valid[idx] && (sb_addr[idx] == word)) begin
        fwd_hit  = 1'b1;
        fwd_data = sb_data[idx];
      end
    end
  end

  assign bus.mem_out = fwd_hit ? fwd_data : mem[word];
  assign sb_count    = count;
  assign sb_empty    = (count == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      sb_valid <= '0;
    end else begin
      // Enqueue is applied after drain so a slot freed this edge can be reused.
      if (do_drain) begin
        sb_valid[head] <= 1'b0;
        head           <= head + 1'b1;
      end
      if (do_enq) begin
        sb_valid[tail] <= 1'b1;
        tail           <= tail + 1'b1;
      end
      case ({do_enq, do_drain})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_enq) begin
      sb_addr[tail] <= word;
      sb_data[tail] <= bus.mem_data;
    end
  end

  always_ff @(posedge clk) begin
    if (do_drain) begin
      mem[sb_addr[head]] <= sb_data[head];
    end
  end

`ifdef DMEM_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_fwd   <= '0;
      stat_drain <= '0;
    end else begin
      if (bus.rd_en && fwd_hit) stat_fwd <= stat_fwd + 32'd1;
      if (do_drain)             stat_drain <= stat_drain + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_store_buffer_dmem.sv
// Scoreboard bench for store_buffer_dmem: architectural and physical memory
// models plus a FIFO model of the pending stores.
module tb_store_buffer_dmem;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 10;

  logic clk = 1'b0;
  logic reset;
  logic [$clog2(DEPTH+1)-1:0] sb_count;
  logic sb_empty;
`ifdef DMEM_STATS_EN
  logic [31:0] stat_fwd;
  logic [31:0] stat_drain;
`endif

  store_buffer_dmem_if bus ();

  store_buffer_dmem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .sb_count   (sb_count),
    .sb_empty   (sb_empty)
`ifdef DMEM_STATS_EN
    ,
    .stat_fwd   (stat_fwd),
    .stat_drain (stat_drain)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          w;
    logic [31:0] d;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] exp_q[$];
  logic [31:0] ref_mem [int];
  logic [31:0] arr_mem [int];
  int          m_fwd;
  int          m_drain;
  int          n_chk = 0;
  int          n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic check_arr(input int w);
    logic [ADDR_W-1:0] wi;
    wi = w[ADDR_W-1:0];
    check_val("array", dut.mem[wi], arr_mem[w]);
  endtask

  // One clock: drive at the falling edge, check the combinational load, advance
  // the models across the rising edge, then check occupancy after it.
  task automatic cyc(input logic rst, input logic me, input logic rd,
                     input logic [31:0] a, input logic [31:0] d);
    int  w;
    bit  hit;
    bit  drn;
    reset        = rst;
    bus.mem_en   = me;
    bus.rd_en    = rd;
    bus.addr     = a;
    bus.mem_data = d;
    w = int'(a[ADDR_W+1:2]);
    #1;
    if (rd) begin
      exp_q.push_back(ref_mem[w]);
      check_val("load", bus.mem_out, exp_q.pop_front());
    end
    if (rst) begin
      mq.delete();
      ref_mem = arr_mem;
      m_fwd   = 0;
      m_drain = 0;
    end else begin
      hit = 0;
      foreach (mq[i]) if (mq[i].w == w) hit = 1;
      if (rd && hit) m_fwd++;
      drn = (mq.size() > 0) && (!rd || (mq.size() == DEPTH && me));
      if (drn) begin
        ent_t e;
        e = mq.pop_front();
        arr_mem[e.w] = e.d;
        m_drain++;
      end
      if (me) begin
        ent_t n;
        n.w = w;
        n.d = d;
        mq.push_back(n);
        ref_mem[w] = d;
      end
    end
    @(posedge clk);
    #1;
    check_val("count", 32'(sb_count), 32'(mq.size()));
    check_val("empty", 32'(sb_empty), 32'(mq.size() == 0));
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int pre_w[10];
    pre_w = '{'h10, 'h20, 'h30, 'h31, 'h32, 'h33, 'h34, 'h40, 'h50, 'h51};
    m_fwd = 0;
    m_drain = 0;
    reset = 1'b1;
    bus.mem_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.addr = '0;
    bus.mem_data = '0;

    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
`ifdef DMEM_STATS_EN
    check_val("stat_fwd_rst", stat_fwd, 32'd0);
    check_val("stat_drain_rst", stat_drain, 32'd0);
`endif

    // Preload every word the bench reads so expected values are defined.
    foreach (pre_w[i]) cyc(0, 1, 0, 32'(pre_w[i] << 2), 32'hA000_0000 | 32'(pre_w[i]));
    cyc(0, 1, 0, 32'h148, 32'hA000_0052);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);

    // Store then load the same word with the array port busy.
    cyc(0, 1, 1, 32'h40, 32'hDEAD_BEEF);
    cyc(0, 0, 1, 32'h40, 0);
    check_val("fwd_deadbeef", bus.mem_out, 32'hDEAD_BEEF);
    check_arr('h10);

    // Two stores to the same word; the younger one must reach the array.
    cyc(0, 1, 1, 32'h80, 32'h1);
    cyc(0, 1, 1, 32'h80, 32'h2);
    cyc(0, 0, 1, 32'h80, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);
    check_arr('h20);
    check_val("dup_youngest", arr_mem['h20], 32'h2);

    // Overfill with the port busy: the fifth store forces out the oldest.
    for (int i = 0; i < 5; i++) cyc(0, 1, 1, 32'hC0 + 32'(i * 4), 32'hC000_0000 + 32'(i));
    check_arr('h30);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 32'hC0 + 32'(i * 4), 0);

    // Full buffer with head at 0x100; store to 0x100 returns the head data.
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 1, 32'h100, 32'h1111_0000);
    cyc(0, 1, 1, 32'h140, 32'h2222_0000);
    cyc(0, 1, 1, 32'h144, 32'h3333_0000);
    cyc(0, 1, 1, 32'h148, 32'h4444_0000);
    cyc(0, 1, 1, 32'h100, 32'h1111_0002);
    check_arr('h40);
    cyc(0, 0, 1, 32'h100, 0);

    // Reset with pending stores and a drain that would otherwise happen.
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 32'h140 + 32'(i * 4), 32'h5500_0000 + 32'(i));
    cyc(1, 0, 0, 0, 0);
    check_arr('h50);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 32'h140 + 32'(i * 4), 0);

    // Statistics: two forwarded loads and three drains since reset.
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 32'h140 + 32'(i * 4), 32'h6600_0000 + 32'(i));
    cyc(0, 0, 1, 32'h140, 0);
    cyc(0, 0, 1, 32'h144, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);
    check_arr('h52);
`ifdef DMEM_STATS_EN
    check_val("stat_fwd", stat_fwd, 32'd2);
    check_val("stat_drain", stat_drain, 32'd3);
    check_val("stat_fwd_model", stat_fwd, 32'(m_fwd));
    check_val("stat_drain_model", stat_drain, 32'(m_drain));
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
